// File: rtl/lsu_dcache_arb_pkg.sv
// lsu_dcache_arb_pkg: payload and tag types shared by the LSU DCache arbiter
package lsu_dcache_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        uncached;
    } iq_lsu_pkg_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } lsu_iq_pkg_t;

    typedef enum logic {
        ARB_IQ = 1'b0,
        ARB_CM = 1'b1
    } arb_src_e;

    typedef struct packed {
        arb_src_e src;
        logic     drop;
    } arb_tag_t;

endpackage

// File: rtl/lsu_arb_tag_fifo.sv
// lsu_arb_tag_fifo: in-order tag FIFO whose flush port marks entries of one source as dropped
module lsu_arb_tag_fifo
    import lsu_dcache_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  arb_tag_t push_tag,
    input  logic     pop,
    input  logic     flush,
    input  arb_src_e flush_src,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    arb_tag_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // head sees a same-cycle flush so a response arriving with the flush is discarded
    always_comb begin
        head      = mem[rd_ptr];
        head.drop = head.drop | (flush & (head.src == flush_src));
    end

    // storage, pointers that wrap on the power-of-2 depth, and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (flush && mem[i].src == flush_src) mem[i].drop <= 1'b1;
            if (do_push) begin
                mem[wr_ptr] <= '{src: push_tag.src, drop: push_tag.drop | (flush & (push_tag.src == flush_src))};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lsu_dcache_arb.sv
// lsu_dcache_arb: shares the DCache port between the LSU IQ and commit requesters
// Optional perf counters are built when LSU_ARB_PERF_EN is defined.
module lsu_dcache_arb
    import lsu_dcache_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        iq_valid_i,
    output logic        iq_ready_o,
    input  iq_lsu_pkg_t iq_req_i,
    input  logic        cm_valid_i,
    output logic        cm_ready_o,
    input  iq_lsu_pkg_t cm_req_i,
    output logic        dc_valid_o,
    input  logic        dc_ready_i,
    output iq_lsu_pkg_t dc_req_o,
    input  logic        dc_resp_valid_i,
    output logic        dc_resp_ready_o,
    input  lsu_iq_pkg_t dc_resp_i,
    output logic        iq_resp_valid_o,
    input  logic        iq_resp_ready_i,
    output logic        cm_resp_valid_o,
    input  logic        cm_resp_ready_i,
    output lsu_iq_pkg_t resp_o,
    output logic        err_o
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [31:0] perf_iq_grant_o,
    output logic [31:0] perf_cm_grant_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, LOCK} lock_e;

    lock_e         lock_q;
    arb_src_e      lock_src_q;
    logic [SW-1:0] starve_q;
    logic          err_q;
    arb_src_e      gnt_src;
    logic          gnt_valid;
    logic          iq_ok;
    logic          dc_hs;
    logic          iq_hs;
    logic          cm_hs;
    logic          fwd;
    logic          fifo_full;
    logic          fifo_empty;
    arb_tag_t      head;

    // grant: a stalled request keeps its source, otherwise cm unless iq is starved or cm idle
    always_comb begin
        iq_ok     = iq_valid_i & ~flush;
        gnt_src   = (lock_q == LOCK) ? lock_src_q :
                    (iq_ok && (starve_q == SW'(STARVE_MAX) || !cm_valid_i)) ? ARB_IQ : ARB_CM;
        gnt_valid = rst_n & ~fifo_full & ((gnt_src == ARB_IQ) ? iq_ok : cm_valid_i);
    end

    assign dc_valid_o = gnt_valid;
    assign dc_req_o   = (gnt_src == ARB_IQ) ? iq_req_i : cm_req_i;
    assign dc_hs      = gnt_valid & dc_ready_i;
    assign iq_hs      = dc_hs & (gnt_src == ARB_IQ);
    assign cm_hs      = dc_hs & (gnt_src == ARB_CM);
    assign iq_ready_o = iq_hs;
    assign cm_ready_o = cm_hs;
    assign resp_o     = dc_resp_i;
    assign err_o      = err_q;

    // response routing: dropped or orphan responses are swallowed, others go to the head's source
    always_comb begin
        fwd             = rst_n & dc_resp_valid_i & ~fifo_empty & ~head.drop;
        iq_resp_valid_o = fwd & (head.src == ARB_IQ);
        cm_resp_valid_o = fwd & (head.src == ARB_CM);
        dc_resp_ready_o = rst_n & dc_resp_valid_i & (fifo_empty | head.drop |
                          ((head.src == ARB_IQ) ? iq_resp_ready_i : cm_resp_ready_i));
    end

    lsu_arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (dc_hs),
        .push_tag  ('{src: gnt_src, drop: 1'b0}),
        .pop       (dc_resp_ready_o),
        .flush     (flush),
        .flush_src (ARB_IQ),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // lock FSM: a presented but unaccepted request pins the grant until it completes or is flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= IDLE;
            lock_src_q <= ARB_IQ;
        end else if (lock_q == LOCK) begin
            if (dc_hs || (flush && lock_src_q == ARB_IQ)) lock_q <= IDLE;
        end else if (gnt_valid && !dc_ready_i) begin
            lock_q     <= LOCK;
            lock_src_q <= gnt_src;
        end
    end

    // starvation counter and sticky orphan-response error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (iq_hs || !iq_valid_i) starve_q <= '0;
            else if (cm_hs && starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + 1'b1;
            if (dc_resp_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

`ifdef LSU_ARB_PERF_EN
    // free-running grant and stall counters; they wrap and ignore flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_iq_grant_o <= '0;
            perf_cm_grant_o <= '0;
            perf_stall_o    <= '0;
        end else begin
            if (iq_hs) perf_iq_grant_o <= perf_iq_grant_o + 32'd1;
            if (cm_hs) perf_cm_grant_o <= perf_cm_grant_o + 32'd1;
            if ((iq_valid_i || cm_valid_i) && !dc_hs) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// tb_lsu_dcache_arb: directed and random stimulus checked against a queue-based model
`timescale 1ns/1ps
module tb_lsu_dcache_arb;
    import lsu_dcache_arb_pkg::*;

    localparam int OUT  = 4;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, iq_valid, cm_valid, dc_ready, rsp_v, iq_rr, cm_rr;
    iq_lsu_pkg_t iq_req, cm_req, dc_req;
    lsu_iq_pkg_t dc_resp, resp;
    logic        iq_ready, cm_ready, dc_valid, dc_resp_ready, iq_resp_valid, cm_resp_valid, err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit src;
        bit drop;
    } mtag_t;

    mtag_t q[$];
    int    starve = 0;
    bit    lk = 0, lk_src = 0, m_err = 0;

    logic [1:0]   obs_rdy, obs_fwd;
    logic         obs_rrdy, obs_err;
    iq_lsu_pkg_t  obs_req;
    logic [1:0]   exp_seq [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    lsu_dcache_arb #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .iq_valid_i      (iq_valid),
        .iq_ready_o      (iq_ready),
        .iq_req_i        (iq_req),
        .cm_valid_i      (cm_valid),
        .cm_ready_o      (cm_ready),
        .cm_req_i        (cm_req),
        .dc_valid_o      (dc_valid),
        .dc_ready_i      (dc_ready),
        .dc_req_o        (dc_req),
        .dc_resp_valid_i (rsp_v),
        .dc_resp_ready_o (dc_resp_ready),
        .dc_resp_i       (dc_resp),
        .iq_resp_valid_o (iq_resp_valid),
        .iq_resp_ready_i (iq_rr),
        .cm_resp_valid_o (cm_resp_valid),
        .cm_resp_ready_i (cm_rr),
        .resp_o          (resp),
        .err_o           (err)
    );

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        flush = 0; iq_valid = 0; cm_valid = 0; dc_ready = 0;
        rsp_v = 0; iq_rr = 0; cm_rr = 0;
        iq_req = {$urandom(), $urandom(), 6'($urandom())};
        cm_req = {$urandom(), $urandom(), 6'($urandom())};
        dc_resp = {$urandom(), 1'($urandom())};
    endtask

    // reset asserted with whatever inputs are currently driven; outputs must drop at once
    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_dc_valid", dc_valid, 0);
        check("rst_iq_ready", iq_ready, 0);
        check("rst_cm_ready", cm_ready, 0);
        check("rst_resp_ready", dc_resp_ready, 0);
        check("rst_resp_valid", {cm_resp_valid, iq_resp_valid}, 0);
        check("rst_err", err, 0);
        q.delete(); starve = 0; lk = 0; lk_src = 0; m_err = 0;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    // one clock: predict from the model, compare, then advance the model at the edge
    task automatic step();
        bit full, iq_ok, src, v, iq_hs, cm_hs, fwd_iq, fwd_cm, rrdy, pop, was_empty;
        mtag_t t;
        #3;
        if (flush) foreach (q[i]) if (q[i].src == 0) q[i].drop = 1;
        full = (q.size() == OUT);
        iq_ok = iq_valid && !flush;
        if (lk) begin
            src = lk_src;
            v = src ? cm_valid : iq_ok;
        end else if (iq_ok && (starve == SMAX || !cm_valid)) begin
            src = 0; v = 1;
        end else begin
            src = 1; v = cm_valid;
        end
        v = v && !full;
        iq_hs = v && dc_ready && !src;
        cm_hs = v && dc_ready && src;
        was_empty = (q.size() == 0);
        fwd_iq = 0; fwd_cm = 0; rrdy = 0;
        if (rsp_v) begin
            if (was_empty || q[0].drop) rrdy = 1;
            else begin
                fwd_iq = !q[0].src;
                fwd_cm = q[0].src;
                rrdy = q[0].src ? cm_rr : iq_rr;
            end
        end
        pop = rrdy && !was_empty;
        obs_rdy = {cm_ready, iq_ready};
        obs_fwd = {cm_resp_valid, iq_resp_valid};
        obs_rrdy = dc_resp_ready;
        obs_err = err;
        obs_req = dc_req;
        check("dc_valid", dc_valid, v);
        if (v) check("dc_req", dc_req, src ? cm_req : iq_req);
        check("iq_ready", iq_ready, iq_hs);
        check("cm_ready", cm_ready, cm_hs);
        check("resp_ready", dc_resp_ready, rrdy);
        check("iq_resp_valid", iq_resp_valid, fwd_iq);
        check("cm_resp_valid", cm_resp_valid, fwd_cm);
        if (fwd_iq || fwd_cm) check("resp", resp, dc_resp);
        check("err", err, m_err);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (iq_hs || cm_hs) begin
            t.src = cm_hs; t.drop = 0;
            q.push_back(t);
        end
        if (rsp_v && was_empty) m_err = 1;
        if (iq_hs || !iq_valid) starve = 0;
        else if (cm_hs && starve < SMAX) starve++;
        if (lk) begin
            if (iq_hs || cm_hs || (lk_src == 0 && flush)) lk = 0;
        end else if (v && !dc_ready) begin
            lk = 1; lk_src = src;
        end
        #1;
    endtask

    task automatic drain();
        set_idle();
        rsp_v = 1; iq_rr = 1; cm_rr = 1;
        for (int k = 0; k < 2 * OUT && q.size() > 0; k++) step();
        set_idle();
    endtask

    initial begin
        set_idle();
        do_reset();
        step();
        step();

        // starvation: cm,cm,cm then forced iq, then cm again
        iq_valid = 1; cm_valid = 1; dc_ready = 1; iq_rr = 1; cm_rr = 1;
        for (int k = 0; k < 5; k++) begin
            rsp_v = (k > 0);
            step();
            check("starve_seq", obs_rdy, exp_seq[k]);
        end
        drain();

        // cm stalled by the DCache: payload held, iq kept out
        cm_valid = 1;
        step();
        iq_valid = 1;
        step();
        check("cm_held_req", obs_req, cm_req);
        check("cm_held_rdy", obs_rdy, 2'b00);
        dc_ready = 1;
        step();
        check("cm_held_hs", obs_rdy, 2'b10);
        cm_valid = 0;
        step();
        drain();

        // iq stalled by the DCache stays granted when cm shows up
        iq_valid = 1;
        step();
        cm_valid = 1;
        step();
        check("iq_lock_req", obs_req, iq_req);
        check("iq_lock_rdy", obs_rdy, 2'b00);
        dc_ready = 1;
        step();
        check("iq_lock_hs", obs_rdy, 2'b01);
        drain();

        // fill the FIFO with iq traffic; full blocks even while a response pops
        do_reset();
        iq_valid = 1; dc_ready = 1;
        for (int k = 0; k < OUT; k++) begin
            step();
            check("fill_hs", obs_rdy, 2'b01);
        end
        step();
        check("full_block", obs_rdy, 2'b00);
        rsp_v = 1; iq_rr = 1;
        step();
        check("full_pop_block", obs_rdy, 2'b00);
        check("full_pop_fwd", obs_fwd, 2'b01);
        rsp_v = 0;
        step();
        check("after_pop_hs", obs_rdy, 2'b01);
        drain();

        // iq,cm,iq then flush: only the cm response is forwarded
        do_reset();
        dc_ready = 1;
        iq_valid = 1; step();
        iq_valid = 0; cm_valid = 1; step();
        cm_valid = 0; iq_valid = 1; step();
        iq_valid = 0; flush = 1; step();
        flush = 0; rsp_v = 1; iq_rr = 1; cm_rr = 1;
        step(); check("flush_r0", obs_fwd, 2'b00); check("flush_r0_rdy", obs_rrdy, 1);
        step(); check("flush_r1", obs_fwd, 2'b10); check("flush_r1_rdy", obs_rrdy, 1);
        step(); check("flush_r2", obs_fwd, 2'b00); check("flush_r2_rdy", obs_rrdy, 1);
        set_idle();
        step();

        // response in the same cycle as the flush, iq at head
        do_reset();
        iq_valid = 1; dc_ready = 1; step();
        set_idle();
        flush = 1; rsp_v = 1; iq_rr = 1;
        step();
        check("same_flush_fwd", obs_fwd, 2'b00);
        check("same_flush_rdy", obs_rrdy, 1);
        set_idle();
        step();

        // orphan response sets the sticky error
        do_reset();
        rsp_v = 1; iq_rr = 1; cm_rr = 1;
        step();
        check("orphan_rdy", obs_rrdy, 1);
        check("orphan_fwd", obs_fwd, 2'b00);
        set_idle();
        for (int k = 0; k < 3; k++) step();
        check("err_sticky", obs_err, 1);

        // random traffic with a reset asserted mid-stream
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            iq_valid = ($urandom_range(0, 9) < 7);
            cm_valid = ($urandom_range(0, 9) < 5);
            dc_ready = ($urandom_range(0, 9) < 6);
            rsp_v    = ($urandom_range(0, 9) < 5);
            iq_rr    = ($urandom_range(0, 9) < 7);
            cm_rr    = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 11) == 0);
            iq_req   = {$urandom(), $urandom(), 6'($urandom())};
            cm_req   = {$urandom(), $urandom(), 6'($urandom())};
            dc_resp  = {$urandom(), 1'($urandom())};
            if (n == 1500) begin
                iq_valid = 1; cm_valid = 1; dc_ready = 1; rsp_v = 1; iq_rr = 1; cm_rr = 1; flush = 0;
                do_reset();
            end
            step();
        end
        set_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arb.md
Name: lsu_dcache_arb

Overview:
Arbiter sharing the single DCache request/response port between two requesters.
- Speculative LSU issue queue: requester 0, "iq".
- Non-speculative commit-side requester: requester 1, "cm". It carries uncached store replay and cacop.
Tracks in-flight requests in an in-order tag FIFO and routes each DCache response back to its originator. Discards responses belonging to flushed speculative requests. Sits between the LSU IQ / commit logic and the DCache.

Parameters:
OUTSTANDING, 4, max in-flight DCache requests; power of 2, >= 2.
STARVE_MAX, 3, consecutive cm grants while iq waits before iq is forced a grant.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; affects iq traffic only
iq_valid_i  in  1  iq request valid
iq_ready_o  out  1  iq request accepted
iq_req_i  in  $bits(iq_lsu_pkg_t)  iq request payload
cm_valid_i  in  1  cm request valid
cm_ready_o  out  1  cm request accepted
cm_req_i  in  $bits(iq_lsu_pkg_t)  cm request payload
dc_valid_o  out  1  request to DCache
dc_ready_i  in  1  DCache accepts request
dc_req_o  out  $bits(iq_lsu_pkg_t)  muxed payload
dc_resp_valid_i  in  1  DCache response valid
dc_resp_ready_o  out  1  response consumed
dc_resp_i  in  $bits(lsu_iq_pkg_t)  response payload
iq_resp_valid_o  out  1  response to iq
iq_resp_ready_i  in  1  iq accepts response
cm_resp_valid_o  out  1  response to cm
cm_resp_ready_i  in  1  cm accepts response
resp_o  out  $bits(lsu_iq_pkg_t)  response payload, shared by both sinks
err_o  out  1  sticky: response seen with FIFO empty

Behaviour:
Reset and outputs:
- Async reset clears all state: FIFO empty, lock_q=0, starve_q=0, err_o=0.
- With inputs idle, every valid/ready output is 0 after reset.

Arbitration (combinational grant, zero latency):
- Eligible only when FIFO is not full and no lock conflict.
- Default priority is cm.
- iq wins when starve_q==STARVE_MAX, or cm_valid_i=0.
- iq is ineligible during any cycle with flush=1.
- Payload: dc_req_o = payload of the granted source. dc_valid_o = granted source valid.
- Handshake: iq_ready_o / cm_ready_o = dc_ready_i & granted-to-that-source & eligible.

Lock state (IDLE/LOCK):
- IDLE→LOCK when dc_valid_o=1 & dc_ready_i=0; lock_src_q records the source.
- In LOCK the grant is forced to lock_src_q.
- LOCK→IDLE on the handshake.
- LOCK→IDLE on flush when lock_src_q=iq; the request is abandoned, and the DCache also sees flush.

Starvation counter:
- starve_q increments, saturating at STARVE_MAX, on a cm handshake while iq_valid_i=1.
- Clears on an iq handshake.
- Clears when iq_valid_i=0.

Tag FIFO:
- Entry = {src, drop}. Push on every dc handshake.
- Pop on every dc response handshake.
- Full means count==OUTSTANDING. Full blocks the grant even if a pop occurs in the same cycle.
- Pointers wrap modulo OUTSTANDING. Count width is clog2(OUTSTANDING)+1.

Response routing (combinational), using the FIFO head:
- drop=1: dc_resp_ready_o=1, nothing forwarded.
- Otherwise: forward valid to head src; dc_resp_ready_o = that sink's ready.
- resp_o = dc_resp_i always.

Flush:
- Sets drop on every FIFO entry with src=iq, effective for the head in the same cycle, so a same-cycle response is discarded.
- cm entries are untouched.

Empty-FIFO response:
- dc_resp_valid_i with FIFO empty: dc_resp_ready_o=1, response discarded, err_o set until reset.

Optional Feature:
LSU_ARB_PERF_EN:
- Defined: adds outputs perf_iq_grant_o, perf_cm_grant_o, perf_stall_o, each 32-bit.
  - The grant counters count handshakes.
  - perf_stall_o counts cycles with any request valid and no handshake.
  - All three wrap, reset to 0, and do not clear on flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: arb_src_e (ARB_IQ=0, ARB_CM=1) and arb_tag_t {src, drop}. iq_lsu_pkg_t and lsu_iq_pkg_t are reused from the existing package.
- One sub-module: lsu_arb_tag_fifo. It is a parameterised FIFO with a flush-marks-drop-by-src port and exposes head/full/empty.

Test Plan:
- Both valid, dc_ready_i=1 for 5 cycles → grants cm,cm,cm,iq,cm; starve_q reaches 3 and then clears.
- cm valid, dc_ready_i=0 for 2 cycles, iq raised in cycle 1 → dc_req_o stays cm payload until the handshake; iq_ready_o=0 throughout.
- 4 iq handshakes with no responses → FIFO full; a 5th iq request sees iq_ready_o=0, including in a cycle where a response pops.
- Push iq,cm,iq; flush; 3 responses → only the middle reaches cm_resp_valid_o; both iq responses are consumed silently.
- Response arrives in the same cycle as flush with iq at the head → not forwarded; dc_resp_ready_o=1.
- dc_resp_valid_i=1 with FIFO empty → err_o=1 next cycle and stays set; assert rst_n=0 mid-traffic → all outputs 0 immediately.
